// File: rtl/read_xbar_if.sv
// ----------------------------------------------------------------------------
// read_xbar_if -- bus bundle for the read_xbar crossbar.
//
// Agent side (m_*):
//   m_rdreq    per-agent read request
//   m_rdsel    per-agent target bank index, SELECT_WIDTH bits each
//   m_rdaddr   per-agent read address, ADDR_WIDTH bits each
//   m_rdgnt    per-agent grant, request accepted this cycle
//   m_rdvalid  per-agent read data valid
//   m_rddata   per-agent read data, DATA_WIDTH bits each
//   m_rderr    per-agent error, qualifies m_rdvalid
// Bank side (s_*):
//   s_rden     per-bank read enable
//   s_rdaddr   per-bank read address
//   s_rddata   per-bank read data, valid RDLAT cycles after s_rden
//
// Modports:
//   slave  -- the crossbar itself
//   master -- the environment around it (agents plus memory banks)
// ----------------------------------------------------------------------------
interface read_xbar_if #(
  parameter int ADDR_WIDTH   = 8,
  parameter int DATA_WIDTH   = 32,
  parameter int NB_BANK      = 2,
  parameter int NB_RDAGENT   = 2,
  parameter int SELECT_WIDTH = (NB_BANK == 1) ? 1 : $clog2(NB_BANK)
);

  logic [NB_RDAGENT-1:0]              m_rdreq;
  logic [NB_RDAGENT*SELECT_WIDTH-1:0] m_rdsel;
  logic [NB_RDAGENT*ADDR_WIDTH-1:0]   m_rdaddr;
  logic [NB_RDAGENT-1:0]              m_rdgnt;
  logic [NB_RDAGENT-1:0]              m_rdvalid;
  logic [NB_RDAGENT*DATA_WIDTH-1:0]   m_rddata;
  logic [NB_RDAGENT-1:0]              m_rderr;

  logic [NB_BANK-1:0]                 s_rden;
  logic [NB_BANK*ADDR_WIDTH-1:0]      s_rdaddr;
  logic [NB_BANK*DATA_WIDTH-1:0]      s_rddata;

  modport slave (
    input  m_rdreq, m_rdsel, m_rdaddr, s_rddata,
    output m_rdgnt, m_rdvalid, m_rddata, m_rderr, s_rden, s_rdaddr
  );

  modport master (
    output m_rdreq, m_rdsel, m_rdaddr, s_rddata,
    input  m_rdgnt, m_rdvalid, m_rddata, m_rderr, s_rden, s_rdaddr
  );

endinterface

// File: rtl/read_xbar.sv
// ----------------------------------------------------------------------------
// read_xbar -- read crossbar between NB_RDAGENT agents and NB_BANK banks.
//
// Each bank owns an independent round-robin arbiter. A grant is combinational
// from the requests and the arbiter pointer; the bank sees s_rden/s_rdaddr in
// the grant cycle and returns data RDLAT cycles later. Each agent carries a
// RDLAT-deep {valid, err, bank} shift register so the returning data can be
// steered back without any further arbitration. Selectors that name a
// non-existent bank are accepted at once, touch no bank, and come back as an
// error response with all-zero data.
//
// Ports:
//   aclk     clock, rising edge
//   aresetn  asynchronous active-low reset
//   bus      read_xbar_if.slave, agent-side and bank-side signals
//
// Build option:
//   READ_XBAR_OUTREG_EN  when defined, m_rdvalid/m_rderr/m_rddata get one
//                        extra register stage (response latency RDLAT+1);
//                        the grant path is unaffected.
// ----------------------------------------------------------------------------
module read_xbar #(
  parameter int ADDR_WIDTH   = 8,
  parameter int DATA_WIDTH   = 32,
  parameter int NB_BANK      = 2,
  parameter int NB_RDAGENT   = 2,
  parameter int RDLAT        = 1,
  parameter int SELECT_WIDTH = (NB_BANK == 1) ? 1 : $clog2(NB_BANK)
) (
  input logic        aclk,
  input logic        aresetn,
  read_xbar_if.slave bus
);

  localparam int AGENT_W = (NB_RDAGENT == 1) ? 1 : $clog2(NB_RDAGENT);

  // --------------------------------------------------------------------------
  // Unpacked views of the flattened buses
  // --------------------------------------------------------------------------
  logic [NB_RDAGENT-1:0][SELECT_WIDTH-1:0] sel;
  logic [NB_RDAGENT-1:0][ADDR_WIDTH-1:0]   addr;
  logic [NB_BANK-1:0][DATA_WIDTH-1:0]      bank_data;

  assign sel       = bus.m_rdsel;
  assign addr      = bus.m_rdaddr;
  assign bank_data = bus.s_rddata;

  // --------------------------------------------------------------------------
  // Request decode
  // Requests are masked while reset is asserted so that no grant, bank enable
  // or pointer movement can leak out of a held-in-reset crossbar.
  // --------------------------------------------------------------------------
  logic [NB_RDAGENT-1:0]              oor;
  logic [NB_BANK-1:0][NB_RDAGENT-1:0] bank_req;

  always_comb begin
    oor      = '0;
    bank_req = '0;
    for (int i = 0; i < NB_RDAGENT; i++) begin
      if (aresetn && bus.m_rdreq[i]) begin
        if (32'(sel[i]) >= NB_BANK) begin
          oor[i] = 1'b1;
        end
        for (int b = 0; b < NB_BANK; b++) begin
          if (sel[i] == SELECT_WIDTH'(b)) begin
            bank_req[b][i] = 1'b1;
          end
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Per-bank round-robin arbitration
  // Scan starts at the bank's pointer and wraps; the first requester found
  // wins and the pointer moves to the agent just above the winner.
  // --------------------------------------------------------------------------
  logic [NB_BANK-1:0][AGENT_W-1:0]    ptr_q;
  logic [NB_BANK-1:0][AGENT_W-1:0]    ptr_d;
  logic [NB_BANK-1:0][NB_RDAGENT-1:0] bank_gnt;
  logic [NB_BANK-1:0]                 bank_hit;
  int                                 arb_idx;

  always_comb begin
    ptr_d    = ptr_q;
    bank_gnt = '0;
    bank_hit = '0;
    arb_idx  = 0;
    for (int b = 0; b < NB_BANK; b++) begin
      for (int j = 0; j < NB_RDAGENT; j++) begin
        arb_idx = (int'(ptr_q[b]) + j) % NB_RDAGENT;
        if (!bank_hit[b] && bank_req[b][arb_idx]) begin
          bank_hit[b]          = 1'b1;
          bank_gnt[b][arb_idx] = 1'b1;
          ptr_d[b]             = AGENT_W'((arb_idx + 1) % NB_RDAGENT);
        end
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  // --------------------------------------------------------------------------
  // Grant and bank-side outputs
  // --------------------------------------------------------------------------
  logic [NB_RDAGENT-1:0]              gnt;
  logic [NB_BANK-1:0][ADDR_WIDTH-1:0] rdaddr_bank;

  always_comb begin
    gnt = oor;
    for (int b = 0; b < NB_BANK; b++) begin
      gnt = gnt | bank_gnt[b];
    end
  end

  // Grants per bank are one-hot, so OR-ing the masked addresses selects the
  // winner's address and leaves all-zero on an idle bank.
  always_comb begin
    rdaddr_bank = '0;
    for (int b = 0; b < NB_BANK; b++) begin
      for (int i = 0; i < NB_RDAGENT; i++) begin
        if (bank_gnt[b][i]) begin
          rdaddr_bank[b] = rdaddr_bank[b] | addr[i];
        end
      end
    end
  end

  assign bus.m_rdgnt  = gnt;
  assign bus.s_rden   = bank_hit;
  assign bus.s_rdaddr = rdaddr_bank;

  // --------------------------------------------------------------------------
  // Response tracking: stage 0 captures the grant, stage RDLAT-1 lines up
  // with the cycle in which the bank drives its data.
  // --------------------------------------------------------------------------
  logic [RDLAT-1:0][NB_RDAGENT-1:0]                   pipe_vld_q, pipe_vld_d;
  logic [RDLAT-1:0][NB_RDAGENT-1:0]                   pipe_err_q, pipe_err_d;
  logic [RDLAT-1:0][NB_RDAGENT-1:0][SELECT_WIDTH-1:0] pipe_sel_q, pipe_sel_d;

  always_comb begin
    pipe_vld_d    = pipe_vld_q;
    pipe_err_d    = pipe_err_q;
    pipe_sel_d    = pipe_sel_q;
    pipe_vld_d[0] = gnt;
    pipe_err_d[0] = oor;
    pipe_sel_d[0] = sel;
    for (int k = 1; k < RDLAT; k++) begin
      pipe_vld_d[k] = pipe_vld_q[k-1];
      pipe_err_d[k] = pipe_err_q[k-1];
      pipe_sel_d[k] = pipe_sel_q[k-1];
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      pipe_vld_q <= '0;
      pipe_err_q <= '0;
      pipe_sel_q <= '0;
    end else begin
      pipe_vld_q <= pipe_vld_d;
      pipe_err_q <= pipe_err_d;
      pipe_sel_q <= pipe_sel_d;
    end
  end

  // --------------------------------------------------------------------------
  // Response steering: pick the recorded bank's data, zero for idle agents
  // and for out-of-range (error) responses.
  // --------------------------------------------------------------------------
  logic [NB_RDAGENT-1:0]                 rsp_vld;
  logic [NB_RDAGENT-1:0]                 rsp_err;
  logic [NB_RDAGENT-1:0][DATA_WIDTH-1:0] rsp_data;

  always_comb begin
    rsp_vld  = pipe_vld_q[RDLAT-1];
    rsp_err  = pipe_err_q[RDLAT-1] & pipe_vld_q[RDLAT-1];
    rsp_data = '0;
    for (int i = 0; i < NB_RDAGENT; i++) begin
      for (int b = 0; b < NB_BANK; b++) begin
        if (rsp_vld[i] && !rsp_err[i] &&
            (pipe_sel_q[RDLAT-1][i] == SELECT_WIDTH'(b))) begin
          rsp_data[i] = bank_data[b];
        end
      end
    end
  end

`ifdef READ_XBAR_OUTREG_EN
  logic [NB_RDAGENT-1:0]                 out_vld_q, out_vld_d;
  logic [NB_RDAGENT-1:0]                 out_err_q, out_err_d;
  logic [NB_RDAGENT-1:0][DATA_WIDTH-1:0] out_data_q, out_data_d;

  always_comb begin
    out_vld_d  = rsp_vld;
    out_err_d  = rsp_err;
    out_data_d = rsp_data;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      out_vld_q  <= '0;
      out_err_q  <= '0;
      out_data_q <= '0;
    end else begin
      out_vld_q  <= out_vld_d;
      out_err_q  <= out_err_d;
      out_data_q <= out_data_d;
    end
  end

  assign bus.m_rdvalid = out_vld_q;
  assign bus.m_rderr   = out_err_q;
  assign bus.m_rddata  = out_data_q;
`else
  assign bus.m_rdvalid = rsp_vld;
  assign bus.m_rderr   = rsp_err;
  assign bus.m_rddata  = rsp_data;
`endif

endmodule
